// File: rtl/step_sched_pkg.sv
// Shared constants and FSM encoding for the step scheduler.
// Optional remaining-steps output is enabled with STEP_SCHED_REMAIN_EN.
package step_sched_pkg;

  localparam int unsigned ClkFreqDefault = 50_000_000;
  localparam int unsigned MinHalf        = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/step_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot winner is the first set req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic                 valid
);

  localparam int unsigned IdW = $clog2(N);

  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IdW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/step_scheduler.sv
// Shares one rate divider among N_JOINTS step requesters via round-robin arbitration.
// Define STEP_SCHED_REMAIN_EN to add the 'remaining' step-count output.
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ = ClkFreqDefault,
  parameter int unsigned N_JOINTS = 4,
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned DIV_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_JOINTS-1:0]          req,
  input  logic [N_JOINTS*STEP_W-1:0]   req_steps,
  input  logic [N_JOINTS*DIV_W-1:0]    req_half,
  input  logic                         abort,
  output logic [N_JOINTS-1:0]          gnt,
  output logic [N_JOINTS-1:0]          done,
  output logic                         busy,
  output logic [$clog2(N_JOINTS)-1:0]  active_id,
  output logic [N_JOINTS-1:0]          step_out,
`ifdef STEP_SCHED_REMAIN_EN
  output logic [STEP_W-1:0]            remaining,
`endif
  output logic                         step_pulse
);

  localparam int unsigned IdW = $clog2(N_JOINTS);

  if (N_JOINTS < 2 || CLK_FREQ == 0) begin : g_param_check
    $error("step_scheduler: N_JOINTS must be >= 2 and CLK_FREQ nonzero");
  end

  state_e              state;
  logic [N_JOINTS-1:0] arb_win;
  logic                arb_valid;
  logic [IdW-1:0]      arb_id;
  logic [IdW-1:0]      rr_ptr;
  logic [IdW-1:0]      next_ptr;
  logic [STEP_W-1:0]   steps_q;
  logic [STEP_W-1:0]   step_cnt;
  logic [DIV_W-1:0]    half_q;
  logic [DIV_W-1:0]    half_eff;
  logic [DIV_W-1:0]    div_cnt;
  logic                cur_out;
  logic                term;
  logic                div_wrap;
  logic                do_grant;
  logic                do_abort;
  logic                do_finish;
  logic                do_tick;
  logic                do_rise;

  rr_arbiter #(
    .N(N_JOINTS)
  ) u_arb (
    .req  (req),
    .ptr  (rr_ptr),
    .win  (arb_win),
    .valid(arb_valid)
  );

  always_comb begin
    arb_id = '0;
    for (int unsigned i = 0; i < N_JOINTS; i++) begin
      if (arb_win[i]) arb_id = IdW'(i);
    end
  end

  assign half_eff = (half_q < DIV_W'(MinHalf)) ? DIV_W'(MinHalf) : half_q;
  assign div_wrap = (div_cnt == half_eff - DIV_W'(1));
  assign cur_out  = step_out[active_id];
  // All steps issued and the wave is back low: only the final exit remains.
  assign term     = (step_cnt == steps_q) && !cur_out;
  assign next_ptr = (active_id == IdW'(N_JOINTS - 1)) ? '0 : active_id + 1'b1;

  assign do_grant  = (state == StIdle) && arb_valid;
  assign do_abort  = (state == StRun) && abort;
  // The gnt-cycle guard holds a zero-step job in RUN for one extra cycle.
  assign do_finish = (state == StRun) && !abort && term && (gnt == '0);
  assign do_tick   = (state == StRun) && !abort && !term && div_wrap;
  assign do_rise   = do_tick && !cur_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
      step_out   <= '0;
      step_pulse <= 1'b0;
      div_cnt    <= '0;
      step_cnt   <= '0;
      rr_ptr     <= '0;
      steps_q    <= '0;
      half_q     <= '0;
    end else begin
      gnt        <= '0;
      done       <= '0;
      step_pulse <= 1'b0;
      unique case (state)
        StIdle: begin
          if (do_grant) begin
            gnt       <= arb_win;
            busy      <= 1'b1;
            active_id <= arb_id;
            steps_q   <= req_steps[arb_id*STEP_W +: STEP_W];
            half_q    <= req_half[arb_id*DIV_W +: DIV_W];
            div_cnt   <= '0;
            step_cnt  <= '0;
            state     <= StRun;
          end
        end
        StRun: begin
          if (do_abort) begin
            step_out <= '0;
            busy     <= 1'b0;
            rr_ptr   <= next_ptr;
            state    <= StIdle;
          end else if (do_finish) begin
            done[active_id] <= 1'b1;
            busy            <= 1'b0;
            rr_ptr          <= next_ptr;
            state           <= StDone;
          end else if (do_tick) begin
            div_cnt             <= '0;
            step_out[active_id] <= ~cur_out;
            if (do_rise) begin
              step_pulse <= 1'b1;
              step_cnt   <= step_cnt + 1'b1;
            end
          end else if (!term) begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

`ifdef STEP_SCHED_REMAIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
    end else if (do_grant) begin
      remaining <= req_steps[arb_id*STEP_W +: STEP_W];
    end else if (do_abort || do_finish) begin
      remaining <= '0;
    end else if (do_rise) begin
      remaining <= remaining - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_step_scheduler.sv
// Self-checking bench for step_scheduler: timeline model plus directed and random stimulus.
// Also checks 'remaining' when built with STEP_SCHED_REMAIN_EN.
module tb_step_scheduler;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req;
  logic [N*SW-1:0] req_steps;
  logic [N*DW-1:0] req_half;
  logic          abort;
  logic [N-1:0]  gnt, done, step_out;
  logic          busy, step_pulse;
  logic [1:0]    active_id;
`ifdef STEP_SCHED_REMAIN_EN
  logic [SW-1:0] remaining;
`endif

  always #5 clk = ~clk;

  step_scheduler #(
    .CLK_FREQ(50_000_000),
    .N_JOINTS(N),
    .STEP_W  (SW),
    .DIV_W   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_steps (req_steps),
    .req_half  (req_half),
    .abort     (abort),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .active_id (active_id),
    .step_out  (step_out),
`ifdef STEP_SCHED_REMAIN_EN
    .remaining (remaining),
`endif
    .step_pulse(step_pulse)
  );

  int errors = 0;
  int checks = 0;

  // Model: a job is a timeline (grant cycle, joint, steps, effective half, done cycle).
  int unsigned cyc;
  bit          running;
  int unsigned g_m, e_m, w_m, s_m, h_m, ptr_m, aid_m;
  logic [N-1:0] clr_req;

  // Observations of the DUT, used by the directed literal checks.
  int unsigned gnt_cycs[$];
  int unsigned gnt_ids[$];
  int unsigned pulse_cycs[$];
  int unsigned done_cnt, done_cyc;
  logic [N-1:0] done_last, done_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned onehot_idx(input logic [N-1:0] v);
    int unsigned r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int unsigned qat(input int unsigned q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_obs();
    gnt_cycs.delete();
    gnt_ids.delete();
    pulse_cycs.delete();
    done_cnt  = 0;
    done_cyc  = 0;
    done_last = '0;
    done_acc  = '0;
  endtask

  task automatic set_job(input int j, input int unsigned s, input int unsigned h);
    req_steps[j*SW +: SW] = SW'(s);
    req_half[j*DW +: DW]  = DW'(h);
  endtask

  task automatic model_reset();
    running = 1'b0;
    ptr_m   = 0;
    aid_m   = 0;
    clr_req = '0;
  endtask

  task automatic compare_cycle();
    logic [N-1:0] eg, ed, eo;
    logic eb, ep;
    int unsigned rel, ph, rises, er;
    eg = '0; ed = '0; eo = '0; eb = 1'b0; ep = 1'b0; er = 0;
    if (running) begin
      rel = cyc - g_m;
      if (cyc == e_m) begin
        ed[w_m] = 1'b1;
      end else begin
        eb = 1'b1;
        if (rel == 0) eg[w_m] = 1'b1;
        ph = rel / h_m;
        if (s_m != 0 && (ph % 2) == 1 && ph < 2 * s_m) begin
          eo[w_m] = 1'b1;
          if (rel % h_m == 0) ep = 1'b1;
        end
        rises = (ph + 1) / 2;
        if (rises > s_m) rises = s_m;
        er = s_m - rises;
      end
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("done", 64'(done), 64'(ed));
    chk("busy", 64'(busy), 64'(eb));
    chk("active_id", 64'(active_id), 64'(aid_m));
    chk("step_out", 64'(step_out), 64'(eo));
    chk("step_pulse", 64'(step_pulse), 64'(ep));
`ifdef STEP_SCHED_REMAIN_EN
    chk("remaining", 64'(remaining), 64'(er));
`endif
    if (gnt != '0) begin
      gnt_cycs.push_back(cyc);
      gnt_ids.push_back(onehot_idx(gnt));
    end
    if (step_pulse) pulse_cycs.push_back(cyc);
    if (done != '0) begin
      done_cnt++;
      done_cyc  = cyc;
      done_last = done;
      done_acc  = done_acc | done;
    end
  endtask

  // Effect of the clock edge that ends the current cycle, from the current inputs.
  task automatic model_edge();
    int unsigned j, h;
    if (!running) begin
      if (req != '0) begin
        for (int i = N - 1; i >= 0; i--) begin
          j = (ptr_m + i) % N;
          if (req[j]) w_m = j;
        end
        running = 1'b1;
        g_m     = cyc + 1;
        s_m     = req_steps[w_m*SW +: SW];
        h       = req_half[w_m*DW +: DW];
        h_m     = (h == 0) ? 1 : h;
        e_m     = (s_m == 0) ? g_m + 2 : g_m + 2 * s_m * h_m + 1;
        aid_m   = w_m;
        clr_req[w_m] = 1'b1;
      end
    end else if (cyc < e_m && abort) begin
      running = 1'b0;
      ptr_m   = (w_m + 1) % N;
    end else if (cyc == e_m) begin
      running = 1'b0;
      ptr_m   = (w_m + 1) % N;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    req     = req & ~clr_req;
    clr_req = '0;
    compare_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, g0, a_cyc;
    req = '0; req_steps = '0; req_half = '0; abort = 1'b0;
    cyc = 0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    compare_cycle();
    rst = 1'b1;

    // Contention from reset: grant order 0,1,2,3, one IDLE cycle between jobs.
    for (int j = 0; j < N; j++) set_job(j, 1, 2);
    clear_obs();
    req = 4'b1111;
    run(32);
    chk("cont_n_gnt", 64'(gnt_ids.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("cont_order", 64'(qat(gnt_ids, k)), 64'(k));
    for (int k = 0; k < 3; k++)
      chk("cont_gap", 64'(qat(gnt_cycs, k + 1) - qat(gnt_cycs, k)), 64'd7);
    chk("cont_dones", 64'(done_cnt), 64'd4);

    // Single job: joint 2, 3 steps, half 5.
    clear_obs();
    t = cyc;
    set_job(2, 3, 5);
    req = 4'b0100;
    run(40);
    chk("single_gnt_lat", 64'(qat(gnt_cycs, 0) - t), 64'd1);
    chk("single_gnt_id", 64'(qat(gnt_ids, 0)), 64'd2);
    chk("single_npulse", 64'(pulse_cycs.size()), 64'd3);
    chk("single_rise0", 64'(qat(pulse_cycs, 0) - t), 64'd6);
    chk("single_rise1", 64'(qat(pulse_cycs, 1) - t), 64'd16);
    chk("single_rise2", 64'(qat(pulse_cycs, 2) - t), 64'd26);
    chk("single_done_t", 64'(done_cyc - t), 64'd32);
    chk("single_done_id", 64'(done_last), 64'b0100);

    // Zero steps on joint 1: done two cycles after gnt, no toggles.
    clear_obs();
    set_job(1, 0, 3);
    req = 4'b0010;
    run(8);
    chk("zero_s_done", 64'(done_cyc - qat(gnt_cycs, 0)), 64'd2);
    chk("zero_s_pulses", 64'(pulse_cycs.size()), 64'd0);

    // Half of zero behaves as one.
    clear_obs();
    set_job(1, 2, 0);
    req = 4'b0010;
    run(10);
    chk("zero_h_rise0", 64'(qat(pulse_cycs, 0) - qat(gnt_cycs, 0)), 64'd1);
    chk("zero_h_rise1", 64'(qat(pulse_cycs, 1) - qat(gnt_cycs, 0)), 64'd3);
    chk("zero_h_done", 64'(done_cyc - qat(gnt_cycs, 0)), 64'd5);

    // Abort after the 3rd step pulse; joint 3 waits behind.
    clear_obs();
    set_job(0, 10, 4);
    set_job(3, 1, 1);
    req = 4'b0001;
    tick();
    req[3] = 1'b1;
    for (int k = 0; k < 200 && pulse_cycs.size() < 3; k++) tick();
    chk("abort_pulses", 64'(pulse_cycs.size()), 64'd3);
    a_cyc = cyc;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out_low", 64'(step_out), 64'd0);
    run(20);
    chk("abort_no_done0", 64'(done_acc[0]), 64'd0);
    chk("abort_next_id", 64'(qat(gnt_ids, 1)), 64'd3);
    chk("abort_next_t", 64'(qat(gnt_cycs, 1) - a_cyc), 64'd2);

    // Abort in the last RUN cycle still suppresses done.
    clear_obs();
    set_job(2, 1, 3);
    req = 4'b0100;
    tick();
    g0 = cyc;
    chk("coinc_gnt", 64'(gnt), 64'b0100);
    repeat (6) tick();
    chk("coinc_model_end", 64'(e_m - g_m), 64'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(6);
    chk("coinc_no_done", 64'(done_cnt), 64'd0);
    chk("coinc_g0", 64'(qat(gnt_cycs, 0)), 64'(g0));

    // Asynchronous reset mid-RUN on joint 3, then ptr restarts at 0.
    set_job(3, 3, 3);
    req = 4'b1000;
    tick();
    run(4);
    chk("pre_reset_out", 64'(step_out), 64'b1000);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step_out", 64'(step_out), 64'd0);
    chk("rst_active_id", 64'(active_id), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    compare_cycle();
    clear_obs();
    set_job(1, 1, 1);
    set_job(3, 1, 1);
    req = 4'b1010;
    run(6);
    chk("post_reset_id", 64'(qat(gnt_ids, 0)), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < N; j++) begin
        if (!req[j] && $urandom_range(0, 7) == 0) req[j] = 1'b1;
        else if (req[j] && $urandom_range(0, 39) == 0) req[j] = 1'b0;
        set_job(j, $urandom_range(0, 4), $urandom_range(0, 5));
      end
      abort = ($urandom_range(0, 49) == 0);
      tick();
    end
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
